instr_dispatch: RTL and testbench

INSTR_DISPATCH -- requirements
Module: instr_dispatch

---
 rtl/qc_pkg.sv | 31 +++
 rtl/instr_decode.sv | 34 +++
 rtl/instr_dispatch.sv | 166 ++++++++++++++++
 tb/tb_instr_dispatch.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/qc_pkg.sv
// Shared definitions for the instruction dispatcher: opcodes, instruction
// field positions and FSM state encoding.
package qc_pkg;

    localparam int INSTR_W     = 56;
    localparam int OPC_MSB     = 55;
    localparam int OPC_LSB     = 52;
    localparam int FPGA_MSB    = 51;
    localparam int FPGA_LSB    = 46;
    localparam int QUBIT_MSB   = 45;
    localparam int QUBIT_LSB   = 40;
    localparam int PAYLOAD_MSB = 39;
    localparam int PAYLOAD_LSB = 0;

    localparam int IDX_W     = 6;
    localparam int PAYLOAD_W = 40;
    localparam int TIMER_W   = 16;

    typedef enum logic [3:0] {
        OP_NOP  = 4'h0,
        OP_GATE = 4'h1,
        OP_WAIT = 4'h2
    } opcode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_e;

endpackage

// File: rtl/instr_decode.sv
// Combinational split of a queue word into its fields, opcode classification
// and target range check against the configured FPGA/qubit counts.
import qc_pkg::*;

module instr_decode #(
    parameter int NUM_FPGA           = 50,
    parameter int NUM_QUBIT_PER_FPGA = 64
) (
    input  logic [INSTR_W-1:0]   instruction,
    output logic                 is_gate,
    output logic                 is_wait,
    output logic                 bad_op,
    output logic                 bad_range,
    output logic [IDX_W-1:0]     fpga,
    output logic [IDX_W-1:0]     qubit,
    output logic [PAYLOAD_W-1:0] payload
);

    logic [3:0] opcode;

    assign opcode  = instruction[OPC_MSB:OPC_LSB];
    assign fpga    = instruction[FPGA_MSB:FPGA_LSB];
    assign qubit   = instruction[QUBIT_MSB:QUBIT_LSB];
    assign payload = instruction[PAYLOAD_MSB:PAYLOAD_LSB];

    assign is_gate = (opcode == OP_GATE);
    assign is_wait = (opcode == OP_WAIT);
    assign bad_op  = !((opcode == OP_NOP) || is_gate || is_wait);

    // Widened by one bit so a count of 64 is representable.
    assign bad_range = ({1'b0, fpga}  >= 7'(NUM_FPGA)) ||
                       ({1'b0, qubit} >= 7'(NUM_QUBIT_PER_FPGA));

endmodule

// File: rtl/instr_dispatch.sv
// Pops instructions from a FWFT queue and issues GATEs / runs WAIT timers.
// Optional DISPATCH_STATS_EN adds saturating issued/error counters.
import qc_pkg::*;

module instr_dispatch #(
    parameter int NUM_FPGA           = 50,
    parameter int NUM_QUBIT_PER_FPGA = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [INSTR_W-1:0]   instruction,
    input  logic                 queue_empty,
    output logic                 pop,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [IDX_W-1:0]     out_fpga,
    output logic [IDX_W-1:0]     out_qubit,
    output logic [PAYLOAD_W-1:0] out_payload,
    output logic                 busy,
    output logic                 err_bad_fpga,
    output logic                 err_bad_op
`ifdef DISPATCH_STATS_EN
    ,
    output logic [31:0]          issued_cnt,
    output logic [15:0]          err_cnt
`endif
);

    logic                 dec_is_gate;
    logic                 dec_is_wait;
    logic                 dec_bad_op;
    logic                 dec_bad_range;
    logic [IDX_W-1:0]     dec_fpga;
    logic [IDX_W-1:0]     dec_qubit;
    logic [PAYLOAD_W-1:0] dec_payload;

    instr_decode #(
        .NUM_FPGA           (NUM_FPGA),
        .NUM_QUBIT_PER_FPGA (NUM_QUBIT_PER_FPGA)
    ) u_decode (
        .instruction (instruction),
        .is_gate     (dec_is_gate),
        .is_wait     (dec_is_wait),
        .bad_op      (dec_bad_op),
        .bad_range   (dec_bad_range),
        .fpga        (dec_fpga),
        .qubit       (dec_qubit),
        .payload     (dec_payload)
    );

    state_e               state_q;
    logic [TIMER_W-1:0]   timer_q;
    logic                 run_q;
    logic                 out_valid_q;
    logic [IDX_W-1:0]     out_fpga_q;
    logic [IDX_W-1:0]     out_qubit_q;
    logic [PAYLOAD_W-1:0] out_payload_q;
    logic                 busy_q;
    logic                 err_bad_fpga_q;
    logic                 err_bad_op_q;

    // run_q is cleared by reset so the combinational pop stays low while
    // rst_n is asserted, without feeding the async reset into datapath logic.
    assign pop = run_q && (state_q == ST_IDLE) && !queue_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            timer_q        <= '0;
            run_q          <= 1'b0;
            out_valid_q    <= 1'b0;
            out_fpga_q     <= '0;
            out_qubit_q    <= '0;
            out_payload_q  <= '0;
            busy_q         <= 1'b0;
            err_bad_fpga_q <= 1'b0;
            err_bad_op_q   <= 1'b0;
        end else begin
            run_q          <= 1'b1;
            err_bad_fpga_q <= 1'b0;
            err_bad_op_q   <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (pop) begin
                        if (dec_bad_op) begin
                            err_bad_op_q <= 1'b1;
                        end else if (dec_is_gate) begin
                            if (dec_bad_range) begin
                                err_bad_fpga_q <= 1'b1;
                            end else begin
                                state_q       <= ST_ISSUE;
                                busy_q        <= 1'b1;
                                out_valid_q   <= 1'b1;
                                out_fpga_q    <= dec_fpga;
                                out_qubit_q   <= dec_qubit;
                                out_payload_q <= dec_payload;
                            end
                        end else if (dec_is_wait) begin
                            state_q <= ST_WAIT;
                            busy_q  <= 1'b1;
                            timer_q <= dec_payload[TIMER_W-1:0];
                        end
                    end
                end
                ST_ISSUE: begin
                    if (out_ready) begin
                        state_q     <= ST_IDLE;
                        busy_q      <= 1'b0;
                        out_valid_q <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (timer_q == '0) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        timer_q <= timer_q - 1'b1;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    busy_q      <= 1'b0;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign out_valid    = out_valid_q;
    assign out_fpga     = out_fpga_q;
    assign out_qubit    = out_qubit_q;
    assign out_payload  = out_payload_q;
    assign busy         = busy_q;
    assign err_bad_fpga = err_bad_fpga_q;
    assign err_bad_op   = err_bad_op_q;

`ifdef DISPATCH_STATS_EN
    logic [31:0] issued_cnt_q, issued_cnt_d;
    logic [15:0] err_cnt_q, err_cnt_d;

    always_comb begin
        issued_cnt_d = issued_cnt_q;
        err_cnt_d    = err_cnt_q;
        if (out_valid_q && out_ready && (issued_cnt_q != '1)) begin
            issued_cnt_d = issued_cnt_q + 32'd1;
        end
        if ((err_bad_fpga_q || err_bad_op_q) && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issued_cnt_q <= '0;
            err_cnt_q    <= '0;
        end else begin
            issued_cnt_q <= issued_cnt_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    assign issued_cnt = issued_cnt_q;
    assign err_cnt    = err_cnt_q;
`endif

endmodule

// File: tb/tb_instr_dispatch.sv
// Scoreboard bench for instr_dispatch: directed words feed a queue model,
// expected issues/errors are queued and checked by an independent monitor.
module tb_instr_dispatch;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [55:0] instruction = '0;
    logic        queue_empty = 1'b1;
    logic        pop;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [5:0]  out_fpga;
    logic [5:0]  out_qubit;
    logic [39:0] out_payload;
    logic        busy;
    logic        err_bad_fpga;
    logic        err_bad_op;

    always #5 clk = ~clk;

    instr_dispatch #(
        .NUM_FPGA           (50),
        .NUM_QUBIT_PER_FPGA (64)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .instruction  (instruction),
        .queue_empty  (queue_empty),
        .pop          (pop),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_fpga     (out_fpga),
        .out_qubit    (out_qubit),
        .out_payload  (out_payload),
        .busy         (busy),
        .err_bad_fpga (err_bad_fpga),
        .err_bad_op   (err_bad_op)
    );

    typedef struct packed {
        logic [5:0]  f;
        logic [5:0]  q;
        logic [39:0] p;
    } gate_t;

    int          checks = 0;
    int          errors = 0;
    int          pop_cnt = 0;
    logic [55:0] iq[$];
    gate_t       exp_gate[$];
    int          exp_err[$];

    function automatic logic [55:0] mk(input logic [3:0] op, input logic [5:0] f,
                                       input logic [5:0] q, input logic [39:0] p);
        return {op, f, q, p};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    task automatic expect_gate(input logic [5:0] f, input logic [5:0] q, input logic [39:0] p);
        gate_t g;
        g.f = f;
        g.q = q;
        g.p = p;
        exp_gate.push_back(g);
    endtask

    // FWFT queue model: sole writer of instruction/queue_empty.
    initial forever begin
        @(clk);
        if (clk && pop) begin
            pop_cnt++;
            if (iq.size() > 0) void'(iq.pop_front());
        end
        #1;
        queue_empty = (iq.size() == 0);
        instruction = queue_empty ? 56'd0 : iq[0];
    end

    // Monitor: scoreboard comparison whenever the DUT presents something.
    always @(negedge clk) begin
        gate_t e;
        int    k;
        #2;
        if (rst_n) begin
            if (pop && queue_empty) begin
                checks++; errors++;
                $display("FAIL pop_while_empty: got pop=1 expected 0");
            end
            if (out_valid && out_ready) begin
                if (exp_gate.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_issue: got fpga=%0d qubit=%0d payload=%0h expected none",
                             out_fpga, out_qubit, out_payload);
                end else begin
                    e = exp_gate.pop_front();
                    check("issue", {out_fpga, out_qubit, out_payload}, {e.f, e.q, e.p});
                end
            end
            if (err_bad_fpga || err_bad_op) begin
                k = (exp_err.size() > 0) ? exp_err.pop_front() : 0;
                check("err_kind", {err_bad_op, err_bad_fpga}, 64'(k));
            end
        end
    end

    initial begin
        int p0;
        int cnt;
        int seen;

        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        int cnt;
        int seen;

        repeat (3) @(negedge clk);
        check("rst_outputs", {pop, out_valid, busy, err_bad_fpga, err_bad_op}, 0);
        check("rst_fields", {out_fpga, out_qubit, out_payload}, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Basic GATE, latency 1
        out_ready = 1'b1;
        p0 = pop_cnt;
        iq.push_back(mk(4'h1, 6'd1, 6'd5, 40'hAB));
        expect_gate(6'd1, 6'd5, 40'hAB);
        @(negedge clk);
        check("gate_pop_count", 64'(pop_cnt - p0), 1);
        check("gate_valid_busy", {out_valid, busy}, 2'b11);
        @(negedge clk);
        check("gate_done", {out_valid, busy}, 0);

        // Out-of-range fpga, then fpga/qubit at the last legal index
        p0 = pop_cnt;
        iq.push_back(mk(4'h1, 6'd50, 6'd0, 40'h1));
        exp_err.push_back(1);
        @(negedge clk);
        check("badfpga_pulse", {pop_cnt == p0 + 1, err_bad_fpga, out_valid, busy}, 4'b1100);
        @(negedge clk);
        check("badfpga_one_cycle", {err_bad_fpga, out_valid}, 0);
        iq.push_back(mk(4'h1, 6'd49, 6'd63, 40'hFF_0000_0001));
        expect_gate(6'd49, 6'd63, 40'hFF_0000_0001);
        iq.push_back(mk(4'h1, 6'd63, 6'd0, 40'h2));
        exp_err.push_back(1);
        repeat (4) @(negedge clk);

        // Back-to-back gates: one every two cycles
        iq.push_back(mk(4'h1, 6'd3, 6'd4, 40'h11));
        iq.push_back(mk(4'h1, 6'd5, 6'd6, 40'h22));
        expect_gate(6'd3, 6'd4, 40'h11);
        expect_gate(6'd5, 6'd6, 40'h22);
        repeat (4) @(negedge clk);
        check("b2b_drained", 64'(exp_gate.size()), 0);

        // WAIT payload=3 -> 4 busy cycles, NOP behind it held in queue
        p0 = pop_cnt;
        iq.push_back(mk(4'h2, 6'd0, 6'd0, 40'd3));
        iq.push_back(mk(4'h0, 6'd0, 6'd0, 40'd0));
        @(negedge clk);
        cnt = 0; seen = 0;
        for (int i = 0; i < 20 && busy; i++) begin
            cnt++;
            if (pop) seen++;
            @(negedge clk);
        end
        check("wait3_busy_cycles", 64'(cnt), 4);
        check("wait3_no_pop", {64'(seen), 64'(pop_cnt - p0)}, {64'd0, 64'd1});
        repeat (2) @(negedge clk);

        // WAIT payload=0 -> 1 busy cycle
        iq.push_back(mk(4'h2, 6'd0, 6'd0, 40'd0));
        @(negedge clk);
        cnt = 0;
        for (int i = 0; i < 20 && busy; i++) begin
            cnt++;
            @(negedge clk);
        end
        check("wait0_busy_cycles", 64'(cnt), 1);

        // Backpressure: ready low for 10 cycles
        out_ready = 1'b0;
        iq.push_back(mk(4'h1, 6'd7, 6'd9, 40'h12345));
        iq.push_back(mk(4'h1, 6'd2, 6'd3, 40'h55));
        expect_gate(6'd7, 6'd9, 40'h12345);
        expect_gate(6'd2, 6'd3, 40'h55);
        @(negedge clk);
        p0 = pop_cnt;
        for (int i = 0; i < 10; i++) begin
            check("stall_stable", {out_valid, out_fpga, out_qubit, out_payload, pop_cnt == p0},
                  {1'b1, 6'd7, 6'd9, 40'h12345, 1'b1});
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("stall_release", {out_valid, busy}, 0);
        repeat (3) @(negedge clk);
        check("stall_drained", 64'(exp_gate.size()), 0);

        // Illegal opcodes and NOP
        iq.push_back(mk(4'hF, 6'd1, 6'd1, 40'd0));
        exp_err.push_back(2);
        @(negedge clk);
        check("badop_pulse", {err_bad_op, err_bad_fpga, out_valid, busy}, 4'b1000);
        iq.push_back(mk(4'h3, 6'd1, 6'd1, 40'd0));
        exp_err.push_back(2);
        @(negedge clk);
        iq.push_back(mk(4'h0, 6'd1, 6'd1, 40'd7));
        repeat (2) @(negedge clk);
        check("nop_quiet", {out_valid, busy, err_bad_op, err_bad_fpga, 64'(iq.size())}, 0);

        // Empty queue: pop must stay low
        p0 = pop_cnt; seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (pop) seen++;
        end
        check("empty_no_pop", {64'(seen), 64'(pop_cnt - p0)}, 0);

        // Reset in the middle of a long WAIT
        iq.push_back(mk(4'h2, 6'd0, 6'd0, 40'd100));
        iq.push_back(mk(4'h0, 6'd0, 6'd0, 40'd0));
        repeat (3) @(negedge clk);
        check("midwait_busy", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        check("midwait_rst_outputs", {pop, out_valid, busy, err_bad_fpga, err_bad_op}, 0);
        check("midwait_rst_fields", {out_fpga, out_qubit, out_payload}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_idle", {busy, out_valid}, 0);
        repeat (3) @(negedge clk);
        iq.push_back(mk(4'h1, 6'd0, 6'd0, 40'h5A));
        expect_gate(6'd0, 6'd0, 40'h5A);
        repeat (3) @(negedge clk);

        for (int i = 0; i < 20 && (exp_gate.size() > 0 || exp_err.size() > 0); i++)
            @(negedge clk);
        check("sb_drained", {64'(exp_gate.size()), 64'(exp_err.size())}, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
